// File: rtl/postproc_pkg.sv
// Shared state type, default widths and MAC product helper for the linear post-process stage.
package postproc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int DW_DEF = 8;
  localparam int WW_DEF = 8;
  localparam int AW_DEF = 32;

  // Operands arrive already sign-extended; callers truncate to the accumulator width.
  function automatic logic signed [63:0] prod64(input logic signed [63:0] d,
                                                input logic signed [63:0] w);
    return d * w;
  endfunction
endpackage

// File: rtl/postproc_mac_lane.sv
// One output channel: load-with-bias / accumulate register plus the held frame result.
module postproc_mac_lane
  import postproc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 step,
  input  logic                 last,
  input  logic signed [DW-1:0] data,
  input  logic signed [WW-1:0] weight,
  input  logic signed [AW-1:0] bias,
  output logic signed [AW-1:0] sum
);
  logic signed [AW-1:0] acc, acc_next, prod;

  assign prod     = AW'(prod64(64'(data), 64'(weight)));
  assign acc_next = (start ? bias : acc) + prod;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc <= '0;
      sum <= '0;
    end else begin
      if (start | step) acc <= acc_next;
      if (last)         sum <= acc_next;
    end
  end
endmodule

// File: rtl/postprocess_linear_nch.sv
// N-channel linear post-process stage: FSM, iter sequencing, output handshake.
// Define POSTPROC_LINEAR_ARGMAX_EN to add a registered argmax stage and the class_out port.
module postprocess_linear_nch
  import postproc_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int N_IN = 288,
  parameter int DW   = DW_DEF,
  parameter int WW   = WW_DEF,
  parameter int AW   = AW_DEF,
  parameter int IW   = 9
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW-1:0]        iter_in,
  input  logic [DW-1:0]        data_in,
  input  logic [N_CH*WW-1:0]   weight_in,
  input  logic [N_CH*AW-1:0]   bias_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH*AW-1:0]   data_out,
  output logic                 seq_err
`ifdef POSTPROC_LINEAR_ARGMAX_EN
  , output logic [$clog2(N_CH)-1:0] class_out
`endif
);
`ifdef POSTPROC_LINEAR_ARGMAX_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  state_t                   state, state_nxt;
  logic [IW-1:0]            exp_idx;
  logic                     accept, is_zero, start, step, last, bad, done;
  logic [STAGES:0]          vld_pipe, vld_nxt;
  logic [N_CH-1:0][AW-1:0]  sums;

  assign in_ready  = (state != HOLD);
  assign accept    = in_valid & in_ready;
  assign is_zero   = (iter_in == '0);
  // iter 0 always (re)starts a frame; ACCUM restart is flagged below
  assign start     = accept & is_zero;
  assign step      = accept & (state == ACCUM) & !is_zero & (iter_in == exp_idx);
  assign last      = (start | step) & (iter_in == LAST_IDX);
  assign bad       = accept & !start & !step;
  assign out_valid = vld_pipe[STAGES];
  assign done      = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (start | step) state_nxt = last ? HOLD : ACCUM;
      HOLD:        if (done) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Top bit stays set until the result is taken
  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = last;
    for (int i = 1; i <= STAGES; i++) vld_nxt[i] = vld_pipe[i-1];
    vld_nxt[STAGES] = vld_nxt[STAGES] | (vld_pipe[STAGES] & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      exp_idx  <= '0;
      seq_err  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= vld_nxt;
      if (start)     exp_idx <= IW'(1);
      else if (step) exp_idx <= exp_idx + 1'b1;
      else if (done) exp_idx <= '0;
      if (start && state == IDLE)                  seq_err <= 1'b0;
      else if (bad || (start && state == ACCUM))   seq_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    postproc_mac_lane #(.DW(DW), .WW(WW), .AW(AW)) u_lane (
      .clk    (clk),
      .rst_b  (rst_b),
      .start  (start),
      .step   (step),
      .last   (last),
      .data   (data_in),
      .weight (weight_in[k*WW +: WW]),
      .bias   (bias_in[k*AW +: AW]),
      .sum    (sums[k])
    );
  end

  assign data_out = sums;

`ifdef POSTPROC_LINEAR_ARGMAX_EN
  localparam int CW = $clog2(N_CH);
  logic [CW-1:0] best;

  // Strict compare keeps the lowest index on ties
  always_comb begin
    best = '0;
    for (int k = 1; k < N_CH; k++)
      if ($signed(sums[k]) > $signed(sums[best])) best = CW'(k);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)           class_out <= '0;
    else if (vld_pipe[0]) class_out <= best;
  end
`endif
endmodule
